// File: rtl/display_7seg_mux_n.sv
// Multiplexed common-anode seven-segment driver with refresh prescaler, per-digit DP,
// leading-zero blanking and optional PWM brightness (enable with DISP_BRIGHTNESS_EN).
module display_7seg_mux_n #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [4*NUM_DIGITS-1:0] dato_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    we_i,
   input  logic                    blank_lz_i,
   input  logic [3:0]              brightness_i,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o
);

   localparam int TICK_N = REFRESH_DIV / 16;
   localparam int TICK_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [TICK_W-1:0]       tick_q;
   logic [3:0]              phase_q;
   logic [IDX_W-1:0]        idx_q;

   logic [NUM_DIGITS-1:0]   zero_from;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_zero;
   logic                    blank;
   logic                    lit;
   logic                    show;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [6:0]              seg_d;
   logic                    dp_d;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;
         4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;
         4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_q <= '0;
         dp_q   <= '0;
      end else if (we_i) begin
         data_q <= dato_i;
         dp_q   <= dp_i;
      end
   end

   // tick -> phase (16 per digit) -> digit index; one digit dwells REFRESH_DIV cycles
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tick_q  <= '0;
         phase_q <= '0;
         idx_q   <= '0;
      end else if (tick_q == TICK_LAST) begin
         tick_q  <= '0;
         phase_q <= phase_q + 4'd1;
         if (phase_q == 4'hF)
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         tick_q <= tick_q + 1'b1;
      end
   end

   // zero_from[k]: nibbles k..top are all zero
   always_comb begin
      logic above;
      above     = 1'b1;
      zero_from = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         above        = above & (data_q[4*k +: 4] == 4'h0);
         zero_from[k] = above;
      end
   end

   always_comb begin
      cur_nib  = '0;
      cur_dp   = 1'b0;
      cur_zero = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IDX_W'(k) == idx_q) begin
            cur_nib  = data_q[4*k +: 4];
            cur_dp   = dp_q[k];
            cur_zero = zero_from[k];
         end
      end
   end

`ifdef DISP_BRIGHTNESS_EN
   assign lit = (phase_q <= brightness_i);
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness_i;
   assign lit = 1'b1;
`endif

   assign blank = blank_lz_i && (idx_q != '0) && cur_zero && !cur_dp;
   assign show  = lit && !blank;

   always_comb begin
      an_d = '1;
      for (int k = 0; k < NUM_DIGITS; k++)
         an_d[k] = !(show && (IDX_W'(k) == idx_q));
      seg_d = blank ? 7'h7F : hex_glyph(cur_nib);
      dp_d  = !(show && cur_dp);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         an_o  <= '1;
         seg_o <= 7'h7F;
         dp_o  <= 1'b1;
      end else begin
         an_o  <= an_d;
         seg_o <= seg_d;
         dp_o  <= dp_d;
      end
   end

endmodule

// File: doc/display_7seg_mux_n.md
Name: display_7seg_mux_n

Overview:
Parametrised multiplexed seven-segment driver and the next generation of the board display block. It latches a write-enabled hex word and scans NUM_DIGITS common-anode digits from an internal refresh prescaler, so no separate display clock is needed. Per-digit decimal points, optional leading-zero blanking and PWM brightness are added. It sits on the processor's memory-mapped display port.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16); data width is 4*NUM_DIGITS.
REFRESH_DIV, 100000, clk_i cycles each digit stays selected; must be a multiple of 16 and at least 16.

Ports:
clk_i  input  1  system clock; sole clock of the block
reset_n_i  input  1  reset, asynchronous, active-low
dato_i  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost
dp_i  input  NUM_DIGITS  decimal-point request per digit, latched with dato_i
we_i  input  1  write strobe; latches dato_i and dp_i
blank_lz_i  input  1  enable leading-zero blanking (level, not latched)
brightness_i  input  4  duty level 0..15; 15 = full on
an_o  output  NUM_DIGITS  anode enables, active-low
seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_o  output  1  decimal point, active-low

Behaviour:
- Async reset (reset_n_i=0): data reg=0, dp reg=0, counters=0, an_o=all 1, seg_o=7'h7F, dp_o=1; held while low.
- Write: we_i=1 at a clk_i edge loads data reg<=dato_i and dp reg<=dp_i. Otherwise the registers hold.
- Prescaler: tick counter runs 0..REFRESH_DIV/16-1. On wrap it advances phase counter 0..15. On phase wrap 15->0 it advances digit index 0..NUM_DIGITS-1, and NUM_DIGITS-1 wraps to 0. Each digit is therefore selected for exactly REFRESH_DIV cycles.
- Blanking of digit k (k>0): blank when blank_lz_i=1, nibbles k..NUM_DIGITS-1 are all zero, and dp reg[k]=0. Digit 0 is never blanked.
- Brightness: the digit is lit when phase <= brightness_i; brightness 0 gives 1/16 duty and 15 gives 16/16. It is never fully dark unless blanked.
- Output register, updated every clk_i:
  - an_o: bit for the current index is 0 when lit and not blanked; all other bits are 1.
  - seg_o: hex decode of the current nibble, standard 0-F glyphs (0=1000000, 1=1111001, ..., 5=0010010, A=0001000, F=0001110). Driven 7'h7F when blanked.
  - dp_o: ~dp reg[index] when lit and not blanked, else 1.
- Latency: we_i sampled at edge n -> register at n -> new glyph on outputs after edge n+1 if that digit is selected. Only one anode is ever low at a time.
- Writing while a digit is displayed: the new value appears from the next output update; no extra blanking.
- Reset mid-scan: outputs go to reset values immediately, without a clock edge. After release, scanning restarts at digit 0, phase 0.
- brightness_i and blank_lz_i are applied combinationally into the output register and take effect the next cycle.

Optional Feature:
DISP_BRIGHTNESS_EN
- Defined: PWM brightness works as above.
- Undefined: brightness_i is ignored and the digit is lit for all 16 phases. The phase counter remains, so scan timing is identical.

Test Plan:
(Each digit dwell = 16 cycles, NUM_DIGITS=4, REFRESH_DIV=16; phase len 1.)
1. Reset: hold reset_n_i=0 -> an_o=4'hF, seg_o=7'h7F, dp_o=1 immediately. After release: seg_o=1000000 and an_o=1110 after the first edge.
2. Write dato_i=16'h12AF, brightness 15, blank_lz 0 -> repeating scan:
   - an 1110, seg 0001110
   - an 1101, seg 0001000
   - an 1011, seg 0100100
   - an 0111, seg 1111001
   Then wrap to digit 0.
3. Leading zeros with dato_i=16'h0005, blank_lz_i=1 -> digit 0 shows seg 0010010; digits 1-3 keep an=1 and seg=7'h7F. dato_i=16'h0000 -> digit 0 shows 1000000.
4. Decimal point with dato_i=16'h0005, dp_i=4'b0100, blank_lz_i=1 -> digit 2 unblanked: an 1011, seg 1000000, dp_o=0. dp_o=1 on all other digits.
5. Brightness 3 with DISP_BRIGHTNESS_EN -> each anode low for exactly 4 of 16 cycles (phases 0-3). With the macro undefined -> low 16/16.
6. Async reset pulse while digit 2 is selected -> outputs reset without a clock edge. After release: digit 0 selected; data reg=0 and displays 0.
